// File: rtl/div_ctrl.sv
`default_nettype none
// ============================================================================
// div_ctrl : sequencing controller between EX-stage M-extension issue and the
//            iterative divider, with a one-entry quotient/remainder cache.
// Revision : 1.0
// ============================================================================
module div_ctrl #(
  parameter int CACHE_EN        = 1,
  parameter int WATCHDOG_CYCLES = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  input  logic [4:0]  req_rd,
  input  logic        flush,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic [4:0]  resp_rd,
  output logic        busy,
  output logic        err,
  output logic        div_start,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  output logic [2:0]  div_funct3,
  input  logic        div_done,
  input  logic [31:0] div_quotient,
  input  logic [31:0] div_remainder
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;
  localparam int         WD_W    = $clog2(WATCHDOG_CYCLES + 1);

  logic [2:0]      state_q, state_d;
  logic [31:0]     rs1_q, rs1_d, rs2_q, rs2_d;
  logic [2:0]      f3_q, f3_d;
  logic [4:0]      rd_q, rd_d;
  logic [31:0]     resp_data_q, resp_data_d;
  logic [4:0]      resp_rd_q, resp_rd_d;
  logic            err_q, err_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            cache_valid_q, cache_valid_d;
  logic [31:0]     cache_rs1_q, cache_rs1_d, cache_rs2_q, cache_rs2_d;
  logic            cache_sgn_q, cache_sgn_d;
  logic [31:0]     cache_quo_q, cache_quo_d, cache_rem_q, cache_rem_d;

  logic            w_accept;
  logic            w_hit;
  logic            w_cache_wr;
  logic [WD_W-1:0] w_wd_inc;
  logic [31:0]     w_div_res;

  // Signed ops (div/rem) have funct3[0]=0; signedness is part of the cache key.
  assign w_accept  = req_valid && (state_q == S_IDLE) && !flush;
  assign w_hit     = (CACHE_EN != 0) && cache_valid_q &&
                     (req_rs1 == cache_rs1_q) && (req_rs2 == cache_rs2_q) &&
                     (!req_funct3[0] == cache_sgn_q);
  assign w_wd_inc  = wd_q + 1'b1;
  assign w_div_res = f3_q[1] ? div_remainder : div_quotient;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      rs1_q         <= '0;
      rs2_q         <= '0;
      f3_q          <= '0;
      rd_q          <= '0;
      resp_data_q   <= '0;
      resp_rd_q     <= '0;
      err_q         <= 1'b0;
      wd_q          <= '0;
      cache_valid_q <= 1'b0;
      cache_rs1_q   <= '0;
      cache_rs2_q   <= '0;
      cache_sgn_q   <= 1'b0;
      cache_quo_q   <= '0;
      cache_rem_q   <= '0;
    end else begin
      state_q       <= state_d;
      rs1_q         <= rs1_d;
      rs2_q         <= rs2_d;
      f3_q          <= f3_d;
      rd_q          <= rd_d;
      resp_data_q   <= resp_data_d;
      resp_rd_q     <= resp_rd_d;
      err_q         <= err_d;
      wd_q          <= wd_d;
      cache_valid_q <= cache_valid_d;
      cache_rs1_q   <= cache_rs1_d;
      cache_rs2_q   <= cache_rs2_d;
      cache_sgn_q   <= cache_sgn_d;
      cache_quo_q   <= cache_quo_d;
      cache_rem_q   <= cache_rem_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    rs1_d         = rs1_q;
    rs2_d         = rs2_q;
    f3_d          = f3_q;
    rd_d          = rd_q;
    resp_data_d   = resp_data_q;
    resp_rd_d     = resp_rd_q;
    err_d         = err_q;
    wd_d          = wd_q;
    cache_valid_d = cache_valid_q;
    cache_rs1_d   = cache_rs1_q;
    cache_rs2_d   = cache_rs2_q;
    cache_sgn_d   = cache_sgn_q;
    cache_quo_d   = cache_quo_q;
    cache_rem_d   = cache_rem_q;
    w_cache_wr    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          if (!req_funct3[2]) begin
            err_d = 1'b1;
          end else begin
            rs1_d = req_rs1;
            rs2_d = req_rs2;
            f3_d  = req_funct3;
            rd_d  = req_rd;
            if (w_hit) begin
              resp_data_d = req_funct3[1] ? cache_rem_q : cache_quo_q;
              resp_rd_d   = req_rd;
              state_d     = S_RESP;
            end else begin
              state_d = S_ISSUE;
            end
          end
        end
      end
      S_ISSUE: begin
        wd_d    = '0;
        state_d = flush ? S_DRAIN : S_WAIT;
      end
      S_WAIT: begin
        if (div_done) begin
          w_cache_wr = 1'b1;
          if (flush) begin
            state_d = S_IDLE;
          end else begin
            resp_data_d = w_div_res;
            resp_rd_d   = rd_q;
            state_d     = S_RESP;
          end
        end else if (flush) begin
          state_d = S_DRAIN;
        end else begin
          wd_d = w_wd_inc;
          if (w_wd_inc == WD_W'(WATCHDOG_CYCLES)) begin
            err_d   = 1'b1;
            state_d = S_DRAIN;
          end
        end
      end
      // The divider cannot abort, so its eventual result is still worth caching.
      S_DRAIN: begin
        if (div_done) begin
          w_cache_wr = 1'b1;
          state_d    = S_IDLE;
        end
      end
      S_RESP: begin
        if (flush || resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (w_cache_wr) begin
      cache_valid_d = 1'b1;
      cache_rs1_d   = rs1_q;
      cache_rs2_d   = rs2_q;
      cache_sgn_d   = !f3_q[0];
      cache_quo_d   = div_quotient;
      cache_rem_d   = div_remainder;
    end
  end

  always_comb begin
    req_ready  = (state_q == S_IDLE);
    busy       = (state_q != S_IDLE);
    div_start  = (state_q == S_ISSUE);
    resp_valid = (state_q == S_RESP);
  end

  assign resp_data    = resp_data_q;
  assign resp_rd      = resp_rd_q;
  assign err          = err_q;
  assign div_dividend = rs1_q;
  assign div_divisor  = rs2_q;
  assign div_funct3   = f3_q;

endmodule
`default_nettype wire

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Sequencing controller between the EX stage M-extension issue logic and the multi-cycle iterative divider.
- Accepts one DIV/DIVU/REM/REMU request at a time over a valid/ready handshake and latches the operands.
- Pulses the divider start, holds the divider inputs stable until div_done, and returns the selected quotient or remainder over a valid/ready response.
- Keeps a one-entry result cache so a REM following a DIV (or the reverse) on identical operands completes without re-running the divider. Supports pipeline flush.

Parameters:
- CACHE_EN, 1: enable the one-entry result cache (0 = every request runs the divider).
- WATCHDOG_CYCLES, 40: maximum cycles in WAIT without div_done before err is raised.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset (rst=0 resets)
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_funct3  in  3  m_funct3_t; only div/divu/rem/remu legal
- req_rs1  in  32  dividend
- req_rs2  in  32  divisor
- req_rd  in  5  destination tag, returned with the result
- flush  in  1  kill the in-flight or pending op
- resp_valid  out  1  result valid
- resp_ready  in  1  consumer takes the result
- resp_data  out  32  quotient (funct3[1]=0) or remainder (funct3[1]=1)
- resp_rd  out  5  tag of the result
- busy  out  1  state != IDLE
- err  out  1  sticky: watchdog expiry or illegal funct3
- div_start  out  1  divider start pulse
- div_dividend  out  32  latched rs1
- div_divisor  out  32  latched rs2
- div_funct3  out  3  latched funct3
- div_done  in  1  divider completion, one-cycle pulse
- div_quotient  in  32  valid only while div_done=1
- div_remainder  in  32  valid only while div_done=1

Behaviour:
- Reset (rst=0, async): state=IDLE; resp_valid=0, div_start=0, busy=0, err=0, resp_data=0, resp_rd=0, operand regs=0, cache_valid=0, watchdog counter=0.
- Operand hold: div_dividend, div_divisor and div_funct3 come only from the latch registers. The latches change only on acceptance in IDLE.
  - This hold is required because the divider reads funct3 and dividend[31] combinationally at done.
- Acceptance: req_ready=1 only in IDLE. A request is accepted when req_valid & req_ready & !flush.
  - On acceptance, latch rs1, rs2, funct3 and rd.
  - If funct3[2]=0 (not a divide op): do not accept; set err; stay IDLE.
- Signed class: sgn = (funct3==div || funct3==rem).
- IDLE:
  - Accepted request with CACHE_EN, cache_valid, rs1==cache_rs1, rs2==cache_rs2 and sgn==cache_sgn: load resp_data from cache_q or cache_r per funct3[1], then -> RESP. resp_valid appears 1 cycle after acceptance.
  - Any other accepted request -> ISSUE.
- ISSUE: div_start=1 for exactly this cycle; clear the watchdog; -> WAIT. If flush is also high, start is still pulsed and the next state is DRAIN.
- WAIT:
  - On div_done: write cache_q/cache_r/cache_rs1/cache_rs2/cache_sgn, set cache_valid, load resp_data/resp_rd, -> RESP.
  - On flush without div_done: -> DRAIN.
  - On flush and div_done in the same cycle: update the cache, no response, -> IDLE.
  - Watchdog increments each WAIT cycle. If it reaches WATCHDOG_CYCLES: set err, -> DRAIN.
- DRAIN: req_ready=0. Wait for div_done (the divider cannot abort), update the cache, -> IDLE. No response is produced.
- RESP:
  - resp_valid=1, and resp_data/resp_rd are held until resp_ready=1, then -> IDLE.
  - flush has priority over resp_ready: flush -> IDLE, response dropped.
- Latency with the current divider (start sampled in its idle state, 32 shift cycles, done state): acceptance at cycle 0, div_start at cycle 1, div_done at cycle 34, resp_valid at cycle 35. Cache hit: resp_valid at cycle 1.
- Divide-by-zero and signed overflow results come from the divider unchanged and may be cached.
- Back-to-back: at most one request per RESP->IDLE pass; no request is accepted in the RESP exit cycle.
- err clears only on reset.

Test Plan:
- Basic DIV: rs1=100, rs2=7 (div) -> div_start pulse at cycle 1, resp_valid at cycle 35, resp_data=14, resp_rd echoed.
- Cache hit: DIV rs1=-100 (0xFFFFFF9C), rs2=7, then REM with the same operands -> second op has no div_start, resp_valid 1 cycle after acceptance, resp_data=0xFFFFFFFE (-2). A following REMU with the same operands misses and runs the divider.
- Special cases: DIVU rs2=0, rs1=0x1234 -> 0xFFFFFFFF; then REMU (same operands) -> 0x1234 from cache. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
- Flush in WAIT at cycle 10 -> no resp_valid, req_ready stays 0 until div_done, then IDLE. A new request is accepted after that and returns a correct result.
- Response backpressure: resp_ready held 0 for 5 cycles -> resp_valid/resp_data stable. flush during RESP -> response dropped and IDLE on the next cycle.
- Async reset asserted mid-WAIT -> all outputs go to reset values immediately, cache_valid=0. Stubbed divider with div_done never asserted -> err=1 after 40 WAIT cycles, state DRAIN. funct3=mul -> err=1, no acceptance.
